// File: rtl/tt_um_nicojeda_prbs31_chk.sv
// PRBS31 (x^31+x^28+1) checker: self-seeds, verifies 64 bits, then counts errors against a flywheel reference.
// One bit per cycle when rx_valid&ena; outputs registered one edge after the bit (uo_out byte mux is combinational).
module tt_um_nicojeda_prbs31_chk (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_BAD    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [30:0] sr_q, sr_d;
  logic [4:0]  seed_cnt_q, seed_cnt_d;
  logic [5:0]  vcnt_q, vcnt_d;
  logic [5:0]  wcnt_q, wcnt_d;
  logic [3:0]  werr_q, werr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        locked_q, locked_d;
  logic        err_pulse_q, err_pulse_d;
  logic        cnt_sat_q, cnt_sat_d;

  logic        bit_vld, d_bit, pred, mism, inc_err;
  logic [30:0] sr_shift;
  logic        unused_inputs;

  assign bit_vld  = ena & ui_in[1];
  assign d_bit    = ui_in[0] ^ ui_in[3];
  assign pred     = sr_q[30] ^ sr_q[27];
  assign mism     = d_bit ^ pred;
  assign sr_shift = {sr_q[29:0], d_bit};
  assign unused_inputs = ^{uio_in, ui_in[7:5]};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    seed_cnt_d  = seed_cnt_q;
    vcnt_d      = vcnt_q;
    wcnt_d      = wcnt_q;
    werr_d      = werr_q;
    err_pulse_d = 1'b0;
    inc_err     = 1'b0;
    case (state_q)
      ST_SEED: begin
        if (bit_vld) begin
          sr_d = sr_shift;
          if (seed_cnt_q == 5'd30) begin
            seed_cnt_d = '0;
            // An all-zero register would predict zeros forever, so reseed instead.
            if (sr_shift != '0) begin
              state_d = ST_VERIFY;
              vcnt_d  = '0;
            end
          end else begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
        end
      end
      ST_VERIFY: begin
        if (bit_vld) begin
          sr_d = sr_shift;
          if (!mism) begin
            vcnt_d = vcnt_q + 6'd1;
            if (vcnt_q == 6'd63) begin
              state_d = ST_LOCKED;
              wcnt_d  = '0;
              werr_d  = '0;
            end
          end else begin
            state_d    = ST_SEED;
            seed_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (bit_vld) begin
          // Shift the prediction, not the received bit, so one bad bit is one error.
          sr_d   = {sr_q[29:0], pred};
          wcnt_d = wcnt_q + 6'd1;
          if (mism) begin
            inc_err     = 1'b1;
            err_pulse_d = 1'b1;
            werr_d      = werr_q + 4'd1;
            if (werr_q == 4'd7) begin
              state_d    = ST_SEED;
              seed_cnt_d = '0;
            end
          end
          if (wcnt_q == 6'd63) werr_d = '0;
        end
      end
      default: begin
        state_d    = ST_SEED;
        seed_cnt_d = '0;
      end
    endcase

    cnt_d = cnt_q;
    if (ui_in[2]) cnt_d = '0;
    else if (inc_err && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

    locked_d  = (state_d == ST_LOCKED);
    cnt_sat_d = (cnt_d == 16'hFFFF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SEED;
      sr_q        <= '0;
      seed_cnt_q  <= '0;
      vcnt_q      <= '0;
      wcnt_q      <= '0;
      werr_q      <= '0;
      cnt_q       <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      cnt_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      seed_cnt_q  <= seed_cnt_d;
      vcnt_q      <= vcnt_d;
      wcnt_q      <= wcnt_d;
      werr_q      <= werr_d;
      cnt_q       <= cnt_d;
      locked_q    <= locked_d;
      err_pulse_q <= err_pulse_d;
      cnt_sat_q   <= cnt_sat_d;
    end
  end

  assign uo_out  = ui_in[4] ? cnt_q[15:8] : cnt_q[7:0];
  assign uio_out = {3'b000, state_q, cnt_sat_q, err_pulse_q, locked_q};
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_nicojeda_prbs31_chk.sv
// Randomized bench for the PRBS31 checker against a queue-based model of the lock/verify/count rules.
module tb_tt_um_nicojeda_prbs31_chk;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  tt_um_nicojeda_prbs31_chk dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Generator: last 31 stream bits, oldest first; next = b[n-31]^b[n-28].
  bit gen[$];
  // Model: last 31 reference bits held by the checker, oldest first.
  bit hist[$];
  int m_state, nseed, nmatch, winpos, winerr;
  logic [15:0] m_cnt;
  bit m_pulse;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit gen_peek();
    return gen[0] ^ gen[3];
  endfunction

  task automatic gen_adv();
    bit b;
    b = gen_peek();
    gen.push_back(b);
    void'(gen.pop_front());
  endtask

  task automatic hist_push(input bit b);
    hist.push_back(b);
    void'(hist.pop_front());
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 31; i++) hist.push_back(1'b0);
    m_state = 0; nseed = 0; nmatch = 0; winpos = 0; winerr = 0;
    m_cnt = 16'h0000; m_pulse = 1'b0;
  endtask

  task automatic model_tick();
    bit v, d, pred, nz;
    v = ena && ui_in[1];
    d = ui_in[0] ^ ui_in[3];
    m_pulse = 1'b0;
    if (v) begin
      pred = hist[0] ^ hist[3];
      case (m_state)
        0: begin
          hist_push(d);
          nseed++;
          if (nseed == 31) begin
            nseed = 0;
            nz = 1'b0;
            foreach (hist[i]) nz |= hist[i];
            if (nz) begin m_state = 1; nmatch = 0; end
          end
        end
        1: begin
          hist_push(d);
          if (d == pred) begin
            nmatch++;
            if (nmatch == 64) begin m_state = 2; winpos = 0; winerr = 0; end
          end else begin
            m_state = 0; nseed = 0;
          end
        end
        default: begin
          hist_push(pred);
          winpos++;
          if (d != pred) begin
            m_pulse = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            winerr++;
            if (winerr == 8) begin m_state = 0; nseed = 0; end
          end
          if (winpos == 64) begin winpos = 0; winerr = 0; end
        end
      endcase
    end
    if (ui_in[2]) m_cnt = 16'h0000;
  endtask

  task automatic step(input bit vld, input bit b, input bit inv, input bit en, input bit clr, input bit bsel);
    logic [7:0] exp_uo, exp_uio;
    logic [1:0] code;
    ui_in  = {3'($urandom), bsel, inv, clr, vld, b};
    uio_in = 8'($urandom);
    ena    = en;
    @(posedge clk);
    model_tick();
    @(negedge clk);
    code    = 2'(m_state);
    exp_uo  = ui_in[4] ? m_cnt[15:8] : m_cnt[7:0];
    exp_uio = {3'b000, code, (m_cnt == 16'hFFFF), m_pulse, (m_state == 2)};
    check_eq("uo_out", {8'h00, uo_out}, {8'h00, exp_uo});
    check_eq("uio_out", {8'h00, uio_out}, {8'h00, exp_uio});
  endtask

  task automatic run_stream(input int n, input bit gappy, input int flip_den, input int clr_den);
    bit vld, en, flip, clr;
    for (int i = 0; i < n; i++) begin
      vld  = gappy ? 1'($urandom_range(1, 0)) : 1'b1;
      en   = gappy ? ($urandom_range(3, 0) != 0) : 1'b1;
      flip = (flip_den != 0) && ($urandom_range(flip_den - 1, 0) == 0);
      clr  = (clr_den != 0) && ($urandom_range(clr_den - 1, 0) == 0);
      step(vld, gen_peek() ^ flip, 1'b0, en, clr, 1'($urandom_range(1, 0)));
      if (vld && en) gen_adv();
    end
  endtask

  task automatic run_to_lock(input bit gappy, input bit invm, output int nb);
    bit vld, en, b;
    nb = 0;
    for (int i = 0; i < 3000 && !uio_out[0]; i++) begin
      vld = gappy ? 1'($urandom_range(1, 0)) : 1'b1;
      en  = gappy ? ($urandom_range(3, 0) != 0) : 1'b1;
      b   = gen_peek();
      step(vld, invm ? ~b : b, invm, en, 1'b0, 1'($urandom_range(1, 0)));
      if (vld && en) begin gen_adv(); nb++; end
    end
    if (!uio_out[0]) nb = 0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_uo", {8'h00, uo_out}, 16'h0000);
    check_eq("arst_uio", {8'h00, uio_out}, 16'h0000);
    model_reset();
    #4 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int  nb;
    bit  b, ever;
    rst_n  = 1'b0;
    ena    = 1'b0;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    for (int i = 0; i < 31; i++) gen.push_back(1'b1);
    model_reset();
    #1;
    check_eq("rst_uo", {8'h00, uo_out}, 16'h0000);
    check_eq("rst_uio", {8'h00, uio_out}, 16'h0000);
    check_eq("uio_oe", {8'h00, uio_oe}, 16'h00FF);
    #12 rst_n = 1'b1;
    @(negedge clk);

    // Clean gapless stream.
    run_to_lock(1'b0, 1'b0, nb);
    check_eq("lock_bits", 16'(nb), 16'd95);
    run_stream(10000 - 95, 1'b0, 0, 0);
    ui_in[4] = 1'b0; #1;
    check_eq("clean_cnt_lo", {8'h00, uo_out}, 16'h0000);
    check_eq("clean_locked", {15'h0, uio_out[0]}, 16'h0001);

    // Single flipped bit.
    b = gen_peek();
    step(1'b1, ~b, 1'b0, 1'b1, 1'b0, 1'b0);
    gen_adv();
    check_eq("flip_pulse", {15'h0, uio_out[1]}, 16'h0001);
    check_eq("flip_cnt", {8'h00, uo_out}, 16'h0001);
    step(1'b1, gen_peek(), 1'b0, 1'b1, 1'b0, 1'b0);
    gen_adv();
    check_eq("flip_pulse_end", {15'h0, uio_out[1]}, 16'h0000);
    check_eq("flip_locked", {15'h0, uio_out[0]}, 16'h0001);

    // Eight errors inside one window: loss of lock, count kept, relock.
    run_stream(1, 1'b0, 0, 1);
    for (int i = 0; i < 70 && winpos != 0; i++) run_stream(1, 1'b0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      step(1'b1, gen_peek() ^ (i % 2 == 0), 1'b0, 1'b1, 1'b0, 1'b0);
      gen_adv();
    end
    check_eq("lol_cnt", {8'h00, uo_out}, 16'd8);
    check_eq("lol_state", {14'h0, uio_out[4:3]}, 16'd0);
    check_eq("lol_locked", {15'h0, uio_out[0]}, 16'h0000);
    run_to_lock(1'b0, 1'b0, nb);
    check_eq("relock_bits", 16'(nb), 16'd95);
    ui_in[4] = 1'b0; #1;
    check_eq("relock_cnt", {8'h00, uo_out}, 16'd8);

    // Async reset while locked, then gappy stream.
    do_reset();
    run_to_lock(1'b1, 1'b0, nb);
    check_eq("gappy_lock_bits", 16'(nb), 16'd95);
    run_stream(3000, 1'b1, 150, 400);

    // Inverted stream.
    do_reset();
    run_to_lock(1'b0, 1'b1, nb);
    check_eq("inv_lock_bits", 16'(nb), 16'd95);
    do_reset();
    ever = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(1'b1, ~gen_peek(), 1'b0, 1'b1, 1'b0, 1'($urandom_range(1, 0)));
      gen_adv();
      ever |= uio_out[0];
    end
    check_eq("inv0_never_locked", {15'h0, ever}, 16'h0000);

    // Saturation, clear and byte select.
    do_reset();
    run_to_lock(1'b0, 1'b0, nb);
    force dut.cnt_q = 16'hFFFE;
    m_cnt = 16'hFFFE;
    run_stream(1, 1'b0, 0, 0);
    release dut.cnt_q;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ~gen_peek(), 1'b0, 1'b1, 1'b0, 1'b0);
      gen_adv();
      run_stream(70, 1'b0, 0, 0);
    end
    check_eq("sat_flag", {15'h0, uio_out[2]}, 16'h0001);
    ui_in[4] = 1'b0; #1;
    check_eq("sat_lo", {8'h00, uo_out}, 16'h00FF);
    ui_in[4] = 1'b1; #1;
    check_eq("sat_hi", {8'h00, uo_out}, 16'h00FF);
    run_stream(1, 1'b0, 0, 1);
    check_eq("clr_sat_flag", {15'h0, uio_out[2]}, 16'h0000);
    step(1'b1, ~gen_peek(), 1'b0, 1'b1, 1'b0, 1'b0);
    gen_adv();
    ui_in[4] = 1'b0; #1;
    check_eq("post_clr_lo", {8'h00, uo_out}, 16'h0001);
    ui_in[4] = 1'b1; #1;
    check_eq("post_clr_hi", {8'h00, uo_out}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tt_um_nicojeda_prbs31_chk.md
TT_UM_NICOJEDA_PRBS31_CHK -- requirements
Module: tt_um_nicojeda_prbs31_chk

Interface
REQ-001 SHALL have ports exactly: clk, rst_n, ena, ui_in, uo_out, uio_in, uio_out, uio_oe.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  design selected; when 0, the block treats every bit as not valid.
REQ-005 ui_in  input  8  [0] rx_bit; [1] rx_valid; [2] clr_cnt; [3] invert; [4] byte_sel; [7:5] unused.
REQ-006 uo_out  output  8  error count byte: byte_sel=0 gives cnt[7:0], byte_sel=1 gives cnt[15:8]; combinational mux.
REQ-007 uio_in  input  8  unused, ignored.
REQ-008 uio_out  output  8  [0] locked; [1] err_pulse; [2] cnt_sat; [4:3] state code; [7:5] 0.
REQ-009 uio_oe  output  8  constant 8'hFF.

Function
REQ-010 Polynomial x^31+x^28+1: predicted bit p = sr[30]^sr[27]; shift is sr <= {sr[29:0], b}.
REQ-011 Effective bit d = rx_bit ^ invert; processing occurs only on cycles with rx_valid=1 and ena=1.
REQ-012 States: SEED (code 0), VERIFY (code 1), LOCKED (code 2); code 3 is unused, and any entry into it returns to SEED next cycle.
REQ-013 SEED: shift d into sr, increment a 5-bit seed_cnt; after the 31st valid bit, go to VERIFY with vcnt=0.
REQ-014 VERIFY: compare d to p and shift d into sr; on match vcnt++; after 64 consecutive matches go to LOCKED; on mismatch go to SEED with seed_cnt=0.
REQ-015 LOCKED: compare d to p; shift p (not d) into sr, making the checker a flywheel reference so a single bit error counts once.
REQ-016 LOCKED mismatch: err_pulse=1 for the cycle after the bit, cnt increments by 1.
REQ-017 cnt is 16-bit, saturating at 16'hFFFF; cnt_sat=1 while cnt==16'hFFFF.
REQ-018 Errors are counted only in LOCKED; mismatches in VERIFY do not touch cnt.
REQ-019 Loss of lock: LOCKED keeps a 6-bit window counter (64 valid bits) and a 4-bit window error count.
REQ-020 On reaching 8 errors within one window, go to SEED next cycle and drop locked; the window restarts on each wrap.
REQ-021 The bit that causes loss of lock is itself counted in cnt.
REQ-022 locked=1 exactly while state==LOCKED; all outputs are registered except uo_out (REQ-006) and uio_oe.
REQ-023 clr_cnt=1 sets cnt=0 on the next edge; it does not affect state or sr.
REQ-024 clr_cnt and a counted error on the same cycle: clear wins, cnt=0.
REQ-025 An all-zero sr is unlockable; if sr==0 when VERIFY would be entered, stay in SEED and restart seed_cnt.
REQ-026 invert changing mid-stream is not special-cased; a burst of mismatches and eventual loss of lock is the required result.

Reset
REQ-027 On rst_n=0, immediately: state=SEED, sr=0, seed_cnt=0, vcnt=0, window counters=0, cnt=0, locked=0, err_pulse=0; uo_out=0, uio_out=0.
REQ-028 Reset mid-operation discards lock; after release, a full SEED+VERIFY (95 valid bits minimum) is required before locked=1.

Verification
REQ-029 Clean PRBS31 from generator state 31'h7FFFFFFF, one bit per cycle -> locked=1 after exactly 95 valid bits; cnt stays 0 for 10,000 bits.
REQ-030 Locked stream, flip one bit -> single err_pulse, cnt=1, locked stays 1.
REQ-031 Locked stream, flip 8 bits inside 64 -> cnt=8, state returns to SEED; stream then clean -> relock after 95 bits; cnt=8 is retained.
REQ-032 Inverted stream with invert=1 -> locks as in REQ-029; invert=0 on the same stream -> never reaches LOCKED.
REQ-033 Force cnt to 16'hFFFE, inject 3 errors (spaced beyond one window) -> cnt=16'hFFFF, cnt_sat=1; clr_cnt -> cnt=0; uo_out correct for byte_sel=0/1.
REQ-034 rx_valid toggling 1/0 and ena=0 gaps -> identical lock point and counts as the gapless case; async rst_n pulse mid-LOCKED -> all outputs 0 immediately.
